fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the jump/branch resolution logic.
- Owns the architectural PC and issues requests to instruction memory over a request/grant plus response-valid interface.
- Presents fetched instructions to decode through a single-entry valid/ready output register.
- Consumes the redirect (jumping) and target (pc_next) produced by jump resolution; on redirect it flushes the buffered instruction and drops any in-flight response.

---
 rtl/cpu_types.sv | 17 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types.sv
// Shared CPU types.
// fetch_state_t : instruction-fetch FSM states
//   IDLE - no memory request in flight
//   WAIT - request granted, its response will be kept
//   KILL - request granted, its response will be discarded (redirect seen)
// NOP_INSTR     : canonical no-op (addi x0,x0,0) shown while no instruction is valid
package cpu_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response channel
// plus the valid/ready channel toward decode.
//   imem_req/imem_addr       fetch -> memory, request and word address
//   imem_gnt                 memory -> fetch, request accepted this cycle
//   imem_rvalid/imem_rdata   memory -> fetch, in-order response
//   out_valid/out_pc/out_instr fetch -> decode, buffered instruction
//   out_ready                decode -> fetch, accepts the instruction
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Owns the PC, keeps at most one request outstanding to instruction memory
// and buffers one fetched instruction for decode. A redirect from the jump
// unit reloads the PC, flushes the buffered instruction and marks any
// in-flight response for discard.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   redirect          jump/branch taken (jump unit's jumping)
//   redirect_pc       jump target (pc_next), bits [1:0] ignored
//   bus               fetch_unit_if.master: imem channel + decode channel
module fetch_unit
  import cpu_types::fetch_state_t;
  import cpu_types::IDLE;
  import cpu_types::WAIT;
  import cpu_types::KILL;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = cpu_types::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         out_valid_q;
  logic [31:0]  out_pc_q;
  logic [31:0]  out_instr_q;
  logic         issue;
  logic         grant;
  logic [1:0]   unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A redirect never coincides with a grant (issue is
  // blocked), so IDLE stays IDLE under redirect without a special case.
  // NOTE: the default assignment up front keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = WAIT;
      WAIT: begin
        if (bus.imem_rvalid)   state_d = IDLE;
        else if (redirect)     state_d = KILL;
      end
      KILL: if (bus.imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: a new request only when nothing is in flight and the
  // output register is empty or draining this cycle, so any response that
  // arrives later always finds room and memory never sees backpressure.
  always_comb begin
    issue = !rst && (state_q == IDLE) && !redirect &&
            (!out_valid_q || bus.out_ready);
    grant = issue && bus.imem_gnt;
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = {pc_q[31:2], 2'b00};

  // PC and address of the request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else if (redirect) begin
      pc_q     <= {redirect_pc[31:2], 2'b00};
    end else if (grant) begin
      req_pc_q <= pc_q;
      pc_q     <= pc_q + 32'd4;  // wraps naturally at 2^32
    end
  end

  // Single-entry output register toward decode. Redirect flushes it; a
  // response that arrives in KILL (or together with a redirect) is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
    end else if (redirect) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
    end else if (state_q == WAIT && bus.imem_rvalid) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= req_pc_q;
      out_instr_q <= bus.imem_rdata;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_instr = out_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed cycle table, hand-written
// reset sequences, then randomized traffic against a program-order model.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic redir, input logic [31:0] rpc, input logic gnt,
                     input logic rv, input logic [31:0] rdata, input logic rdy,
                     input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [31:0] e_instr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_valid ? e_instr : NOP;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic rdy);
    redirect        = redir;
    redirect_pc     = rpc;
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    bus.out_ready   = rdy;
  endtask

  // Random-phase model state
  logic [31:0] exp_pc;
  logic        pending;
  int          cd;
  logic [31:0] paddr;
  logic        prev_stall, prev_hold;
  logic [31:0] prev_addr, prev_pc, prev_instr;
  int          transfers;

  initial begin
    // redir rpc gnt rv rdata rdy | req addr valid pc instr
    add(0, 0, 1, 0, 0,            1, 1, 32'h0,   0, 0, 0);
    add(0, 0, 1, 1, 32'h1111_0000, 1, 0, 32'h4,  0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 32'h4,   1, 32'h0, 32'h1111_0000);
    add(0, 0, 1, 1, 32'h1111_0004, 1, 0, 32'h8,  0, 0, 0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h8,   1, 32'h4, 32'h1111_0004);
    add(0, 0, 0, 0, 0,            1, 1, 32'h8,   0, 0, 0);
    add(0, 0, 0, 0, 0,            1, 1, 32'h8,   0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 32'h8,   0, 0, 0);
    add(0, 0, 1, 1, 32'h1111_0008, 0, 0, 32'hC,  0, 0, 0);
    add(0, 0, 1, 0, 0,            0, 0, 32'hC,   1, 32'h8, 32'h1111_0008);
    add(0, 0, 1, 0, 0,            0, 0, 32'hC,   1, 32'h8, 32'h1111_0008);
    add(0, 0, 1, 0, 0,            1, 1, 32'hC,   1, 32'h8, 32'h1111_0008);
    add(1, 32'h103, 1, 0, 0,      1, 0, 32'h10,  0, 0, 0);
    add(0, 0, 1, 1, JUNK,         1, 0, 32'h100, 0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 32'h100, 0, 0, 0);
    add(1, 32'h200, 1, 1, JUNK,   1, 0, 32'h104, 0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 32'h200, 0, 0, 0);
    add(0, 0, 1, 1, 32'h2222_0200, 1, 0, 32'h204, 0, 0, 0);
    add(1, 32'hFFFF_FFFC, 1, 0, 0, 1, 0, 32'h204, 1, 32'h200, 32'h2222_0200);
    add(0, 0, 1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    add(0, 0, 1, 1, 32'h3333_FFFC, 1, 0, 32'h0,  0, 0, 0);
    add(0, 0, 1, 0, 0,            1, 1, 32'h0,   1, 32'hFFFF_FFFC, 32'h3333_FFFC);

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_out_instr", bus.out_instr, NOP);
    check("rst_out_pc",    bus.out_pc, 32'h0);
    check("rst_imem_req",  32'(bus.imem_req), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].redir, vecs[i].rpc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_req", i),   32'(bus.imem_req),  32'(vecs[i].e_req));
      check($sformatf("v%0d_addr", i),  bus.imem_addr,      vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_instr", i), bus.out_instr,      vecs[i].e_instr);
      if (vecs[i].e_valid) check($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].e_pc);
    end

    // Async reset pulse while a request is in flight (state WAIT, pc=4)
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_wait_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_wait_req",   32'(bus.imem_req),  32'(1'b0));
    #1 rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    check("restart_req",  32'(bus.imem_req), 32'(1'b1));
    check("restart_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h4444_0000, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("restart_valid", 32'(bus.out_valid), 32'(1'b1));
    check("restart_pc",    bus.out_pc, 32'h0);
    check("restart_instr", bus.out_instr, 32'h4444_0000);
    // Async reset with a held instruction: flush is immediate, no clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'(1'b0));
    check("rst_async_instr", bus.out_instr, NOP);
    #1 rst = 1'b0;

    // Randomized traffic against a program-order model
    exp_pc = 32'h0; pending = 1'b0; cd = 0; paddr = '0;
    prev_stall = 1'b0; prev_hold = 1'b0; prev_addr = '0; prev_pc = '0; prev_instr = '0;
    transfers = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (pending && cd == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(paddr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (pending) cd--;
      end
      bus.imem_gnt  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_pc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      #1;
      check("one_outstanding", 32'(bus.imem_req && pending), 32'(1'b0));
      if (!bus.out_valid) check("nop_when_empty", bus.out_instr, NOP);
      if (bus.imem_req) check("addr_aligned", 32'(bus.imem_addr[1:0]), 32'(2'b00));
      if (prev_stall && !redirect) begin
        check("stall_req_held",  32'(bus.imem_req), 32'(1'b1));
        check("stall_addr_held", bus.imem_addr, prev_addr);
      end
      if (prev_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'(1'b1));
        check("hold_pc",    bus.out_pc, prev_pc);
        check("hold_instr", bus.out_instr, prev_instr);
      end
      if (bus.out_valid && bus.out_ready && !redirect) begin
        check("stream_pc",    bus.out_pc, exp_pc);
        check("stream_instr", bus.out_instr, mem_word(bus.out_pc));
        exp_pc = bus.out_pc + 32'd4;
        transfers++;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      if (bus.imem_rvalid) pending = 1'b0;
      if (bus.imem_req && bus.imem_gnt) begin
        pending = 1'b1;
        cd      = $urandom_range(0, 2);
        paddr   = bus.imem_addr;
      end
      prev_stall = bus.imem_req && !bus.imem_gnt;
      prev_addr  = bus.imem_addr;
      prev_hold  = bus.out_valid && !bus.out_ready && !redirect;
      prev_pc    = bus.out_pc;
      prev_instr = bus.out_instr;
    end
    check("random_progress", 32'(transfers > 200), 32'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
